// File: rtl/rv32i_types.sv
// Shared types for the data-side memory path: the eviction write buffer
// state encoding and the cache line width.
package rv32i_types;

    localparam int EWB_LINE_WIDTH = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACK    = 2'd1,
        RD_FWD = 2'd2,
        DRAIN  = 2'd3
    } ewb_state_t;

endpackage

// File: rtl/ewb_entry.sv
// Single buffered line: valid flag, full line address and line data, with a
// combinational tag match against the cache's current request address.
module ewb_entry #(
    parameter int LINE_WIDTH  = 256,
    parameter int ADDR_WIDTH  = 32,
    parameter int OFFSET_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_clear,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [LINE_WIDTH-1:0] i_data,
    input  logic [ADDR_WIDTH-1:0] i_cmp_addr,
    output logic                  o_valid,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [LINE_WIDTH-1:0] o_data,
    output logic                  o_match
);

    logic                  r_valid;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LINE_WIDTH-1:0] r_data;

    // A load always wins over a clear; the controller never asks for both.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_addr  <= i_addr;
            r_data  <= i_data;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_addr  = r_addr;
    assign o_data  = r_data;
    assign o_match = r_valid &&
                     (i_cmp_addr[ADDR_WIDTH-1:OFFSET_BITS] == r_addr[ADDR_WIDTH-1:OFFSET_BITS]);

endmodule

// File: rtl/eviction_write_buffer.sv
// Single-entry write-back buffer between the data cache and the arbiter data
// port: absorbs evictions, serves hits from the entry, drains when idle.
module eviction_write_buffer
    import rv32i_types::*;
#(
    parameter int LINE_WIDTH  = EWB_LINE_WIDTH,
    parameter int ADDR_WIDTH  = 32,
    parameter int OFFSET_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] c_address,
    input  logic                  c_read,
    input  logic                  c_write,
    input  logic [LINE_WIDTH-1:0] c_wdata,
    output logic [LINE_WIDTH-1:0] c_rdata,
    output logic                  c_resp,
    output logic [ADDR_WIDTH-1:0] m_address,
    output logic                  m_read,
    output logic                  m_write,
    output logic [LINE_WIDTH-1:0] m_wdata,
    input  logic [LINE_WIDTH-1:0] m_rdata,
    input  logic                  m_resp,
    output logic                  buf_valid
);

    ewb_state_t            r_state;
    ewb_state_t            w_next;
    logic [LINE_WIDTH-1:0] r_rdata;

    logic                  w_load;
    logic                  w_clear;
    logic                  w_rd_hit;
    logic                  w_valid;
    logic                  w_match;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [LINE_WIDTH-1:0] w_data;

    ewb_entry #(
        .LINE_WIDTH (LINE_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .OFFSET_BITS(OFFSET_BITS)
    ) u_entry (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_clear   (w_clear),
        .i_addr    (c_address),
        .i_data    (c_wdata),
        .i_cmp_addr(c_address),
        .o_valid   (w_valid),
        .o_addr    (w_addr),
        .o_data    (w_data),
        .o_match   (w_match)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_rd_hit) begin
                r_rdata <= w_data;
            end
        end
    end

    // Reads are examined before the background drain so a miss reaches
    // memory ahead of the buffered eviction.
    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_clear   = 1'b0;
        w_rd_hit  = 1'b0;
        c_resp    = 1'b0;
        c_rdata   = r_rdata;
        m_read    = 1'b0;
        m_write   = 1'b0;
        m_address = '0;
        m_wdata   = '0;
        case (r_state)
            IDLE: begin
                if (c_write) begin
                    if (!w_valid || w_match) begin
                        w_load = 1'b1;
                        w_next = ACK;
                    end else begin
                        w_next = DRAIN;
                    end
                end else if (c_read) begin
                    if (w_match) begin
                        w_rd_hit = 1'b1;
                        w_next   = ACK;
                    end else begin
                        w_next = RD_FWD;
                    end
                end else if (w_valid) begin
                    w_next = DRAIN;
                end
            end
            ACK: begin
                c_resp = 1'b1;
                w_next = IDLE;
            end
            RD_FWD: begin
                m_read    = 1'b1;
                m_address = c_address;
                if (m_resp) begin
                    c_resp  = 1'b1;
                    c_rdata = m_rdata;
                    w_next  = IDLE;
                end
            end
            DRAIN: begin
                m_write   = 1'b1;
                m_address = w_addr;
                m_wdata   = w_data;
                if (m_resp) begin
                    w_clear = 1'b1;
                    w_next  = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign buf_valid = w_valid;

endmodule

// File: tb/tb_eviction_write_buffer.sv
// Directed bench for eviction_write_buffer; the arbiter side is driven by
// hand so every handshake cycle is explicit.
module tb_eviction_write_buffer;

    logic         clk;
    logic         rst;
    logic [31:0]  c_address;
    logic         c_read;
    logic         c_write;
    logic [255:0] c_wdata;
    logic [255:0] c_rdata;
    logic         c_resp;
    logic [31:0]  m_address;
    logic         m_read;
    logic         m_write;
    logic [255:0] m_wdata;
    logic [255:0] m_rdata;
    logic         m_resp;
    logic         buf_valid;

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] D1   = {8{32'h1111_AAAA}};
    localparam logic [255:0] D2   = {8{32'h2222_BBBB}};
    localparam logic [255:0] D3   = {8{32'h3333_CCCC}};
    localparam logic [255:0] MEM1 = {8{32'hDEAD_0001}};
    localparam logic [255:0] MEM2 = {8{32'hBEEF_0002}};

    eviction_write_buffer dut (
        .clk      (clk),
        .rst      (rst),
        .c_address(c_address),
        .c_read   (c_read),
        .c_write  (c_write),
        .c_wdata  (c_wdata),
        .c_rdata  (c_rdata),
        .c_resp   (c_resp),
        .m_address(m_address),
        .m_read   (m_read),
        .m_write  (m_write),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_resp   (m_resp),
        .buf_valid(buf_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [255:0] wd);
        c_read    = rd;
        c_write   = wr;
        c_address = addr;
        c_wdata   = wd;
        #1;
    endtask

    // The two arbiter requests must never be raised together.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert (!(m_read && m_write))
            else begin
                errors++;
                $error("[TB] FAIL overlap observed m_read=%0b m_write=%0b expected not both",
                       m_read, m_write);
            end
        end
    end

    initial begin
        rst = 1'b1; m_resp = 1'b0; m_rdata = '0;
        applyStimulus(1'b0, 1'b0, 32'h0, '0);
        tick(); tick();
        rst = 1'b0;
        #1;
        checkOutput("rst_c_resp",    c_resp,    0);
        checkOutput("rst_m_read",    m_read,    0);
        checkOutput("rst_m_write",   m_write,   0);
        checkOutput("rst_buf_valid", buf_valid, 0);
        checkOutput("rst_m_address", m_address, 0);
        checkOutput("rst_c_rdata",   c_rdata,   0);
        checkOutput("rst_m_wdata",   m_wdata,   0);

        // Eviction then miss.
        applyStimulus(1'b0, 1'b1, 32'h0000_1040, D1);
        tick();
        checkOutput("ev_c_resp",    c_resp,    1);
        checkOutput("ev_buf_valid", buf_valid, 1);
        checkOutput("ev_no_write",  m_write,   0);
        applyStimulus(1'b0, 1'b0, 32'h0, '0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0000_2000, '0);
        checkOutput("miss_idle_resp", c_resp, 0);
        tick();
        checkOutput("miss_m_read",  m_read,    1);
        checkOutput("miss_m_addr",  m_address, 32'h0000_2000);
        checkOutput("miss_m_write", m_write,   0);
        checkOutput("miss_wait_resp", c_resp,  0);
        tick();
        checkOutput("miss_hold_read", m_read,  1);
        m_resp = 1'b1; m_rdata = MEM1; #1;
        checkOutput("miss_c_resp",  c_resp,  1);
        checkOutput("miss_c_rdata", c_rdata, MEM1);
        tick();
        m_resp = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, '0);
        checkOutput("post_miss_resp", c_resp, 0);
        tick();
        checkOutput("drain_m_write", m_write,   1);
        checkOutput("drain_m_addr",  m_address, 32'h0000_1040);
        checkOutput("drain_m_wdata", m_wdata,   D1);
        checkOutput("drain_m_read",  m_read,    0);
        m_resp = 1'b1; #1;
        checkOutput("drain_no_c_resp", c_resp, 0);
        tick();
        m_resp = 1'b0; #1;
        checkOutput("drain_done_valid", buf_valid, 0);
        checkOutput("drain_done_write", m_write,   0);

        // Read hit, then overwrite of the same line.
        applyStimulus(1'b0, 1'b1, 32'h0000_1040, D1);
        tick();
        checkOutput("hitsetup_resp", c_resp, 1);
        applyStimulus(1'b0, 1'b0, 32'h0, '0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0000_105C, '0);
        tick();
        checkOutput("hit_c_resp", c_resp,  1);
        checkOutput("hit_c_rdata", c_rdata, D1);
        checkOutput("hit_no_read", m_read,  0);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h0000_1040, D2);
        checkOutput("same_idle_write", m_write, 0);
        tick();
        checkOutput("same_c_resp",  c_resp,  1);
        checkOutput("same_no_write", m_write, 0);
        applyStimulus(1'b0, 1'b0, 32'h0, '0);
        tick(); tick();
        checkOutput("same_drain_addr",  m_address, 32'h0000_1040);
        checkOutput("same_drain_wdata", m_wdata,   D2);

        // Read raised mid-drain with a slow arbiter.
        applyStimulus(1'b1, 1'b0, 32'h0000_4000, '0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("mid_drain_read",  m_read,  0);
            checkOutput("mid_drain_write", m_write, 1);
        end
        m_resp = 1'b1; #1;
        checkOutput("mid_drain_c_resp", c_resp, 0);
        tick();
        m_resp = 1'b0; #1;
        checkOutput("after_drain_read", m_read,    0);
        checkOutput("after_drain_valid", buf_valid, 0);
        tick();
        checkOutput("late_m_read",  m_read,    1);
        checkOutput("late_m_addr",  m_address, 32'h0000_4000);
        checkOutput("late_m_write", m_write,   0);
        m_resp = 1'b1; m_rdata = MEM2; #1;
        checkOutput("late_c_resp",  c_resp,  1);
        checkOutput("late_c_rdata", c_rdata, MEM2);
        tick();
        m_resp = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, '0);

        // Write to a different line while full.
        applyStimulus(1'b0, 1'b1, 32'h0000_1040, D1);
        tick();
        checkOutput("diff_setup_resp", c_resp, 1);
        applyStimulus(1'b0, 1'b0, 32'h0, '0);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h0000_3000, D3);
        tick();
        checkOutput("diff_drain_addr",  m_address, 32'h0000_1040);
        checkOutput("diff_drain_wdata", m_wdata,   D1);
        checkOutput("diff_drain_resp",  c_resp,    0);
        tick();
        m_resp = 1'b1; #1;
        checkOutput("diff_mresp_c_resp", c_resp, 0);
        tick();
        m_resp = 1'b0; #1;
        checkOutput("diff_idle_resp",  c_resp,    0);
        checkOutput("diff_idle_valid", buf_valid, 0);
        tick();
        checkOutput("diff_accept_resp",  c_resp,    1);
        checkOutput("diff_accept_valid", buf_valid, 1);
        applyStimulus(1'b0, 1'b0, 32'h0, '0);
        tick(); tick();
        checkOutput("diff_new_addr",  m_address, 32'h0000_3000);
        checkOutput("diff_new_wdata", m_wdata,   D3);

        // Reset while draining.
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        checkOutput("rstd_m_write",   m_write,   0);
        checkOutput("rstd_m_read",    m_read,    0);
        checkOutput("rstd_c_resp",    c_resp,    0);
        checkOutput("rstd_m_address", m_address, 0);
        checkOutput("rstd_m_wdata",   m_wdata,   0);
        checkOutput("rstd_buf_valid", buf_valid, 0);
        applyStimulus(1'b1, 1'b0, 32'h0000_5000, '0);
        tick();
        checkOutput("rstd_idle_read", m_read,    1);
        checkOutput("rstd_idle_addr", m_address, 32'h0000_5000);
        m_resp = 1'b1; m_rdata = MEM1; #1;
        tick();
        m_resp = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, '0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
